// File: rtl/debounced_pio_in.sv
// Avalon-MM input PIO for push-buttons and slide switches.
// Each channel is optionally inverted, passed through a two-flop synchroniser
// and a per-channel debounce counter; qualified edges are latched into a
// write-1-to-clear capture register that drives a maskable level interrupt.
module debounced_pio_in #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [2:0]  CTRL_RESET      = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_IRQMASK = 2'd1,
        REG_EDGECAP = 2'd2,
        REG_CTRL    = 2'd3
    } reg_addr_t;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    reg_addr_t        addr_sel;
    edge_mode_t       edge_mode;
    logic [2:0]       ctrl;
    logic             inv;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [CW-1:0]    count [WIDTH];
    logic             unused_wdata;

    assign addr_sel     = reg_addr_t'(address);
    assign edge_mode    = edge_mode_t'(ctrl[1:0]);
    assign inv          = ctrl[2];
    assign sync_in      = inv ? ~pio_in : pio_in;
    assign rise         = stable_next & ~stable;
    assign fall         = ~stable_next & stable;
    assign cap_clr      = (write && addr_sel == REG_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign irq          = |(edgecap & irqmask);
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser for the raw (possibly inverted) inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sync_in;
            sync2 <= sync1;
        end
    end

    // A channel accepts its synchronised value once it has differed from stable for a full count
    always_comb begin
        stable_next = stable;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] != stable[i] && count[i] == CNT_MAX) begin
                stable_next[i] = sync2[i];
            end
        end
    end

    // Per-channel debounce counters and debounced state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            stable <= stable_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i] || count[i] == CNT_MAX) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

    // Select which qualified edges are captured
    always_comb begin
        edge_set = '0;
        case (edge_mode)
            EDGE_RISE: edge_set = rise;
            EDGE_FALL: edge_set = fall;
            EDGE_BOTH: edge_set = rise | fall;
            EDGE_NONE: edge_set = '0;
        endcase
    end

    // Control, mask and capture registers; a new edge overrides a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= CTRL_RESET;
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_set;
            if (write && addr_sel == REG_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            if (write && addr_sel == REG_CTRL) begin
                ctrl <= writedata[2:0];
            end
        end
    end

    // Registered read port; holds its last value when no read is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (addr_sel)
                REG_DATA:    readdata <= 32'(stable);
                REG_IRQMASK: readdata <= 32'(irqmask);
                REG_EDGECAP: readdata <= 32'(edgecap);
                REG_CTRL:    readdata <= 32'(ctrl);
            endcase
        end
    end

endmodule
